// File: rtl/mipslite_pkg.sv
// mipslite_pkg -- shared MIPS-lite encoding constants.
//   op_e     : symbolic instruction enum accepted by the loader
//   OPC_* / FN_* : primary opcode and R-type funct fields (also used by the controller)
//   state_e  : loader FSM encoding (ST_SLOT is only reachable with DELAY_SLOT_EN)
//   rtype/itype/jtype : field packers for the three instruction formats
package mipslite_pkg;

  typedef enum logic [3:0] {
    OP_ADDU  = 4'd0,
    OP_SUBU  = 4'd1,
    OP_SLT   = 4'd2,
    OP_JR    = 4'd3,
    OP_ORI   = 4'd4,
    OP_LW    = 4'd5,
    OP_SW    = 4'd6,
    OP_BEQ   = 4'd7,
    OP_LUI   = 4'd8,
    OP_J     = 4'd9,
    OP_JAL   = 4'd10,
    OP_ADDI  = 4'd11,
    OP_ADDIU = 4'd12
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FULL   = 3'd4,
    ST_SLOT   = 3'd5
  } state_e;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, 5'b0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] opc, input logic [25:0] tgt);
    return {opc, tgt};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack -- combinational symbolic-instruction to machine-word packer.
//   op[3:0]            : op_e value; 13..15 are illegal
//   rs, rt, rd [4:0]   : register fields (unused ones are ignored)
//   imm[25:0]          : imm16 in [15:0], full target for j/jal
//   word[31:0]         : encoded instruction (0 when illegal)
//   illegal            : op outside the defined enum
//   xfer               : control transfer (beq/j/jal/jr), i.e. has a delay slot
module instr_pack
  import mipslite_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        xfer
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    xfer    = 1'b0;
    case (op)
      OP_ADDU:  word = rtype(rs, rt, rd, FN_ADDU);
      OP_SUBU:  word = rtype(rs, rt, rd, FN_SUBU);
      OP_SLT:   word = rtype(rs, rt, rd, FN_SLT);
      OP_JR: begin
        word = rtype(rs, 5'd0, 5'd0, FN_JR);
        xfer = 1'b1;
      end
      OP_ORI:   word = itype(OPC_ORI,   rs, rt, imm[15:0]);
      OP_LW:    word = itype(OPC_LW,    rs, rt, imm[15:0]);
      OP_SW:    word = itype(OPC_SW,    rs, rt, imm[15:0]);
      OP_BEQ: begin
        word = itype(OPC_BEQ, rs, rt, imm[15:0]);
        xfer = 1'b1;
      end
      OP_LUI:   word = itype(OPC_LUI, 5'd0, rt, imm[15:0]);
      OP_J: begin
        word = jtype(OPC_J, imm);
        xfer = 1'b1;
      end
      OP_JAL: begin
        word = jtype(OPC_JAL, imm);
        xfer = 1'b1;
      end
      OP_ADDI:  word = itype(OPC_ADDI,  rs, rt, imm[15:0]);
      OP_ADDIU: word = itype(OPC_ADDIU, rs, rt, imm[15:0]);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader -- encodes a valid/ready stream of symbolic instructions
// and writes the words sequentially into instruction memory from BASE_ADDR.
//   clk, reset         : clock, synchronous active-high reset
//   start              : begins a load (honoured in IDLE/DONE/FULL)
//   in_valid/in_ready  : input handshake; in_op/rs/rt/rd/imm/last carry the instruction
//   im_we/im_addr/im_wdata : registered instruction-memory write port
//   word_cnt           : words written since start
//   done / err_full    : levels for DONE / FULL states
//   err_illegal        : one-cycle pulse after accepting op 13..15
// Build option: define DELAY_SLOT_EN to append a nop after every beq/j/jal/jr.
module instr_encoder_loader
  import mipslite_pkg::*;
#(
  parameter int          IM_DEPTH  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_op,
  input  logic [4:0]                in_rs,
  input  logic [4:0]                in_rt,
  input  logic [4:0]                in_rd,
  input  logic [25:0]               in_imm,
  input  logic                      in_last,
  output logic                      im_we,
  output logic [31:0]               im_addr,
  output logic [31:0]               im_wdata,
  output logic [$clog2(IM_DEPTH):0] word_cnt,
  output logic                      done,
  output logic                      err_illegal,
  output logic                      err_full
);

  localparam int CW = $clog2(IM_DEPTH) + 1;

  state_e        state, state_n;
  logic [CW-1:0] word_idx, idx_inc;
  logic          last_q, ill_q;
  logic          hs, bump, clr, slot_wr, at_full;

  logic [31:0]   pk_word;
  logic          pk_illegal, pk_xfer;

  instr_pack u_pack (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .word    (pk_word),
    .illegal (pk_illegal),
    .xfer    (pk_xfer)
  );

`ifdef DELAY_SLOT_EN
  logic xfer_q;
`else
  logic unused_xfer;
  assign unused_xfer = pk_xfer;
`endif

  function automatic logic [31:0] addr_of(input logic [CW-1:0] idx);
    return BASE_ADDR + (32'(idx) << 2);
  endfunction

  assign idx_inc  = word_idx + CW'(1);
  // word_idx never exceeds IM_DEPTH, so only the incremented value needs the test
  assign at_full  = (idx_inc == CW'(IM_DEPTH));
  assign word_cnt = word_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    hs       = 1'b0;
    bump     = 1'b0;
    clr      = 1'b0;
    slot_wr  = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    err_full = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_n = ST_ACCEPT;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          clr     = 1'b1;
          state_n = ST_ACCEPT;
        end
      end
      ST_FULL: begin
        err_full = 1'b1;
        if (start) begin
          clr     = 1'b1;
          state_n = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hs      = 1'b1;
          state_n = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (ill_q) begin
          // illegal op consumed without a write; counter untouched
          state_n = last_q ? ST_DONE : ST_ACCEPT;
        end else begin
          bump = 1'b1;
`ifdef DELAY_SLOT_EN
          if (xfer_q) begin
            if (at_full) state_n = ST_FULL;
            else begin
              state_n = ST_SLOT;
              slot_wr = 1'b1;
            end
          end else begin
            state_n = last_q ? ST_DONE : (at_full ? ST_FULL : ST_ACCEPT);
          end
`else
          state_n = last_q ? ST_DONE : (at_full ? ST_FULL : ST_ACCEPT);
`endif
        end
      end
`ifdef DELAY_SLOT_EN
      ST_SLOT: begin
        bump    = 1'b1;
        state_n = last_q ? ST_DONE : (at_full ? ST_FULL : ST_ACCEPT);
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  // Write port is registered on the handshake edge so the strobe lands in
  // the WRITE cycle; the slot nop is likewise launched on the WRITE->SLOT edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx    <= '0;
      im_we       <= 1'b0;
      im_addr     <= BASE_ADDR;
      im_wdata    <= '0;
      err_illegal <= 1'b0;
      last_q      <= 1'b0;
      ill_q       <= 1'b0;
`ifdef DELAY_SLOT_EN
      xfer_q      <= 1'b0;
`endif
    end else begin
      im_we       <= 1'b0;
      err_illegal <= 1'b0;
      if (clr)  word_idx <= '0;
      if (bump) word_idx <= idx_inc;
      if (hs) begin
        last_q      <= in_last;
        ill_q       <= pk_illegal;
        err_illegal <= pk_illegal;
`ifdef DELAY_SLOT_EN
        xfer_q      <= pk_xfer;
`endif
        if (!pk_illegal) begin
          im_we    <= 1'b1;
          im_addr  <= addr_of(word_idx);
          im_wdata <= pk_word;
        end
      end
      if (slot_wr) begin
        im_we    <= 1'b1;
        im_addr  <= addr_of(idx_inc);
        im_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader -- directed vectors with hand-encoded expected words.
// Uses IM_DEPTH=4 so the full condition is reachable; expectations for
// branch/jump words follow DELAY_SLOT_EN.
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [25:0] in_imm;
  logic        in_ready, im_we, done, err_illegal, err_full;
  logic [31:0] im_addr, im_wdata;
  logic [2:0]  word_cnt;

  int checks = 0;
  int failures = 0;
  int ill_cnt = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always #5 clk = ~clk;

  instr_encoder_loader #(.IM_DEPTH(DEPTH), .BASE_ADDR(32'h0000_3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_imm      (in_imm),
    .in_last     (in_last),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .word_cnt    (word_cnt),
    .done        (done),
    .err_illegal (err_illegal),
    .err_full    (err_full)
  );

  // write / pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (im_we) begin
      wa.push_back(im_addr);
      wd.push_back(im_wdata);
    end
    if (err_illegal) ill_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    ill_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Holds in_valid until accepted (bounded); returns with in_valid low.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [25:0] imm, input logic last,
                      output bit ok);
    int n;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_write(input string tag, input int i, input logic [31:0] a,
                             input logic [31:0] d);
    if (i < wa.size()) begin
      check({tag, "_addr"}, wa[i], a);
      check({tag, "_data"}, wd[i], d);
    end else begin
      check({tag, "_missing"}, 32'(wa.size()), 32'(i + 1));
    end
  endtask

  bit ok;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    cycles(3);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_im_we", 32'(im_we), 0);
    check("rst_im_addr", im_addr, 32'h0000_3000);
    check("rst_im_wdata", im_wdata, 0);
    check("rst_word_cnt", 32'(word_cnt), 0);
    check("rst_flags", {29'b0, done, err_illegal, err_full}, 0);
    reset = 1'b0;
    cycles(2);
    check("idle_in_ready", 32'(in_ready), 0);

    // addu rs=1 rt=2 rd=3
    clear_log();
    pulse_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, ok);
    check("addu_ok", 32'(ok), 1);
    cycles(3);
    check("addu_nwr", 32'(wa.size()), 1);
    check_write("addu", 0, 32'h0000_3000, 32'h0022_1821);
    check("addu_cnt", 32'(word_cnt), 1);
    check("addu_ready", 32'(in_ready), 1);

    // ori / lw (last)
    clear_log();
    cycles(1);
    check("accept_done", 32'(done), 0);
    in_valid = 1'b0;
    // start from ACCEPT is ignored; counter keeps its value
    pulse_start();
    check("start_ign_cnt", 32'(word_cnt), 1);
    reset = 1'b1; cycles(1); reset = 1'b0;
    pulse_start();
    send(4'd4, 5'd0, 5'd1, 5'd0, 26'h1234, 1'b0, ok);
    send(4'd5, 5'd0, 5'd2, 5'd0, 26'd4, 1'b1, ok);
    cycles(3);
    check("orilw_nwr", 32'(wa.size()), 2);
    check_write("ori", 0, 32'h0000_3000, 32'h3401_1234);
    check_write("lw", 1, 32'h0000_3004, 32'h8C02_0004);
    check("orilw_done", 32'(done), 1);
    check("orilw_cnt", 32'(word_cnt), 2);
    check("done_ready", 32'(in_ready), 0);

    // lui (rs forced 0) then j; start from DONE restarts at base
    clear_log();
    pulse_start();
    check("restart_done", 32'(done), 0);
    send(4'd8, 5'd7, 5'd1, 5'd0, 26'hFFFF, 1'b0, ok);
    send(4'd9, 5'd0, 5'd0, 5'd0, 26'h0000C00, 1'b1, ok);
    cycles(4);
    check_write("lui", 0, 32'h0000_3000, 32'h3C01_FFFF);
    check_write("j", 1, 32'h0000_3004, 32'h0800_0C00);
`ifdef DELAY_SLOT_EN
    check_write("j_slot", 2, 32'h0000_3008, 32'h0000_0000);
    check("luij_cnt", 32'(word_cnt), 3);
`else
    check("luij_nwr", 32'(wa.size()), 2);
    check("luij_cnt", 32'(word_cnt), 2);
`endif
    check("luij_done", 32'(done), 1);

    // illegal op 14, then beq (last)
    clear_log();
    pulse_start();
    send(4'd14, 5'd1, 5'd1, 5'd1, 26'h1, 1'b0, ok);
    cycles(2);
    check("ill_pulse", 32'(ill_cnt), 1);
    check("ill_nowr", 32'(wa.size()), 0);
    check("ill_cnt", 32'(word_cnt), 0);
    check("ill_ready", 32'(in_ready), 1);
    send(4'd7, 5'd1, 5'd2, 5'd0, 26'hFFFF, 1'b1, ok);
    cycles(4);
    check_write("beq", 0, 32'h0000_3000, 32'h1022_FFFF);
`ifdef DELAY_SLOT_EN
    check_write("beq_slot", 1, 32'h0000_3004, 32'h0000_0000);
    check("beq_cnt", 32'(word_cnt), 2);
`else
    check("beq_nwr", 32'(wa.size()), 1);
    check("beq_cnt", 32'(word_cnt), 1);
`endif
    check("beq_ill_once", 32'(ill_cnt), 1);

    // fill memory: 5 sends, only 4 accepted
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(4'd1, 5'd4, 5'd5, 5'(i + 8), 26'd0, 1'b0, ok);
      check("full_send_ok", 32'(ok), 1);
    end
    send(4'd1, 5'd4, 5'd5, 5'd12, 26'd0, 1'b0, ok);
    check("full_5th_refused", 32'(ok), 0);
    check("full_nwr", 32'(wa.size()), 4);
    check_write("subu_last", 3, 32'h0000_300C, 32'h0085_5823);
    check("full_flag", 32'(err_full), 1);
    check("full_ready", 32'(in_ready), 0);
    check("full_cnt", 32'(word_cnt), 4);
    check("full_done", 32'(done), 0);
    pulse_start();
    check("full_clear", 32'(err_full), 0);
    check("full_restart_rdy", 32'(in_ready), 1);
    check("full_restart_cnt", 32'(word_cnt), 0);

    // jal (last)
    clear_log();
    send(4'd10, 5'd0, 5'd0, 5'd0, 26'h100, 1'b1, ok);
    cycles(4);
    check_write("jal", 0, 32'h0000_3000, 32'h0C00_0100);
`ifdef DELAY_SLOT_EN
    check_write("jal_slot", 1, 32'h0000_3004, 32'h0000_0000);
    check("jal_cnt", 32'(word_cnt), 2);
`else
    check("jal_nwr", 32'(wa.size()), 1);
    check("jal_cnt", 32'(word_cnt), 1);
`endif
    check("jal_done", 32'(done), 1);

    // reset during the WRITE cycle
    clear_log();
    pulse_start();
    send(4'd11, 5'd3, 5'd4, 5'd0, 26'h8001, 1'b0, ok);
    check("rstw_we_before", 32'(im_we), 1);
    check("rstw_data", im_wdata, 32'h2064_8001);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstw_we", 32'(im_we), 0);
    check("rstw_cnt", 32'(word_cnt), 0);
    check("rstw_addr", im_addr, 32'h0000_3000);
    check("rstw_ready", 32'(in_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
